// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor with start/done handshake.
// Alignment and normalisation shift one bit per clock; rounding is truncation.
module fp_addsub_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] float_a,
   input  logic [31:0] float_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_UNPACK = 3'd1;
   localparam logic [2:0] S_ALIGN  = 3'd2;
   localparam logic [2:0] S_ADD    = 3'd3;
   localparam logic [2:0] S_NORM   = 3'd4;
   localparam logic [2:0] S_PACK   = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [31:0] opa_q, opa_d, opb_q, opb_d;
   logic        sa_q, sa_d, sb_q, sb_d;
   logic [9:0]  exp_q, exp_d;
   logic [26:0] ma_q, ma_d, mb_q, mb_d;
   logic [27:0] sum_q, sum_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        zero_q, zero_d, spec_q, spec_d;
   logic [31:0] spec_val_q, spec_val_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [31:0] result_q, result_d;

   logic        nan_a_s, nan_b_s, inf_a_s, inf_b_s, za_s, zb_s, special_s, swap_s;
   logic [31:0] big_s, small_s, spec_val_s;
   logic [7:0]  diff_s;
   logic [4:0]  shift_s;
   logic [27:0] sum_s;

   // Operand classification, magnitude ordering and special-case result
   always_comb begin
      nan_a_s   = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] != 23'd0);
      nan_b_s   = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] != 23'd0);
      inf_a_s   = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] == 23'd0);
      inf_b_s   = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] == 23'd0);
      za_s      = (opa_q[30:23] == 8'h00);
      zb_s      = (opb_q[30:23] == 8'h00);
      special_s = nan_a_s | nan_b_s | inf_a_s | inf_b_s | za_s | zb_s;
      swap_s    = (opb_q[30:0] > opa_q[30:0]);
      big_s     = swap_s ? opb_q : opa_q;
      small_s   = swap_s ? opa_q : opb_q;
      diff_s    = big_s[30:23] - small_s[30:23];
      shift_s   = (diff_s > 8'd26) ? 5'd26 : diff_s[4:0];
      if (nan_a_s || nan_b_s || (inf_a_s && inf_b_s && (opa_q[31] != opb_q[31]))) begin
         spec_val_s = 32'h7FC0_0000;
      end else if (inf_a_s) begin
         spec_val_s = {opa_q[31], 8'hFF, 23'd0};
      end else if (inf_b_s) begin
         spec_val_s = {opb_q[31], 8'hFF, 23'd0};
      end else if (za_s && zb_s) begin
         spec_val_s = {opa_q[31] & opb_q[31], 31'd0};
      end else if (za_s) begin
         spec_val_s = opb_q;
      end else begin
         spec_val_s = opa_q;
      end
      if (sa_q == sb_q) begin
         sum_s = {1'b0, ma_q} + {1'b0, mb_q};
      end else begin
         sum_s = {1'b0, ma_q} - {1'b0, mb_q};
      end
   end

   // Next-state logic for the sequencer and datapath
   always_comb begin
      state_d    = state_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      exp_d      = exp_q;
      ma_d       = ma_q;
      mb_d       = mb_q;
      sum_d      = sum_q;
      cnt_d      = cnt_q;
      zero_d     = zero_q;
      spec_d     = spec_q;
      spec_val_d = spec_val_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               opa_d   = float_a;
               opb_d   = {float_b[31] ^ op, float_b[30:0]};
               busy_d  = 1'b1;
               state_d = S_UNPACK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_UNPACK: begin
            sa_d       = big_s[31];
            sb_d       = small_s[31];
            exp_d      = {2'b00, big_s[30:23]};
            ma_d       = {1'b1, big_s[22:0], 3'b000};
            mb_d       = {1'b1, small_s[22:0], 3'b000};
            cnt_d      = shift_s;
            zero_d     = 1'b0;
            spec_d     = special_s;
            spec_val_d = spec_val_s;
            if (special_s) begin
               state_d = S_PACK;
            end else if (shift_s == 5'd0) begin
               state_d = S_ADD;
            end else begin
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            mb_d  = {1'b0, mb_q[26:2], mb_q[1] | mb_q[0]};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = S_ADD;
            end else begin
               state_d = S_ALIGN;
            end
         end
         S_ADD: begin
            sum_d = sum_s;
            if (sum_s == 28'd0) begin
               zero_d  = 1'b1;
               sa_d    = 1'b0;
               state_d = S_PACK;
            end else begin
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            // Carry: one right shift keeping sticky; otherwise walk the leading one up to bit 26
            if (sum_q[27]) begin
               sum_d = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
               exp_d = exp_q + 10'd1;
            end else if (sum_q[26]) begin
               state_d = S_PACK;
            end else if (exp_q <= 10'd1) begin
               zero_d  = 1'b1;
               state_d = S_PACK;
            end else begin
               sum_d = {sum_q[26:0], 1'b0};
               exp_d = exp_q - 10'd1;
            end
         end
         S_PACK: begin
            if (spec_q) begin
               result_d = spec_val_q;
            end else if (zero_q) begin
               result_d = {sa_q, 31'd0};
            end else if (exp_q >= 10'd255) begin
               result_d = {sa_q, 8'hFF, 23'd0};
            end else begin
               result_d = {sa_q, exp_q[7:0], sum_q[25:3]};
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         opa_q      <= 32'd0;
         opb_q      <= 32'd0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         exp_q      <= 10'd0;
         ma_q       <= 27'd0;
         mb_q       <= 27'd0;
         sum_q      <= 28'd0;
         cnt_q      <= 5'd0;
         zero_q     <= 1'b0;
         spec_q     <= 1'b0;
         spec_val_q <= 32'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         exp_q      <= exp_d;
         ma_q       <= ma_d;
         mb_q       <= mb_d;
         sum_q      <= sum_d;
         cnt_q      <= cnt_d;
         zero_q     <= zero_d;
         spec_q     <= spec_d;
         spec_val_q <= spec_val_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule
